// File: rtl/dragonfang_pkg.sv
// Shared types for the lane's execution-to-commit path: packet formats,
// the default unit count and the packet conversion helper.
package dragonfang_pkg;

    localparam int DEFAULT_NUM_FUNCTIONAL_UNITS = 4;
    localparam int FU_ID_FIELD_WIDTH            = 4;
    localparam int VREG_ADDR_WIDTH              = 5;
    localparam int VD_WIDTH                     = 32;

    typedef struct packed {
        logic [FU_ID_FIELD_WIDTH-1:0] functional_unit_id;
        logic [VREG_ADDR_WIDTH-1:0]   vector_destination_address;
        logic [VD_WIDTH-1:0]          vd;
    } execution_output_packet_t;

    typedef struct packed {
        logic [VREG_ADDR_WIDTH-1:0] vector_destination_address;
        logic [VD_WIDTH-1:0]        vd;
    } commit_input_packet_t;

    // The unit ID only matters for the slot check done by the caller.
    function automatic commit_input_packet_t pack_execution_to_commit(
        input execution_output_packet_t pkt
    );
        commit_input_packet_t c;
        logic                 unused_id;
        unused_id                    = ^pkt.functional_unit_id;
        c.vector_destination_address = pkt.vector_destination_address;
        c.vd                         = pkt.vd;
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from a start pointer by default,
// fixed lowest-index priority when DRAGONFANG_COMMIT_FIXED_PRIORITY_EN is defined.
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic [INDEX_WIDTH-1:0]    pointer,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [INDEX_WIDTH-1:0]    grant_index,
    output logic                      grant_valid
);

`ifdef DRAGONFANG_COMMIT_FIXED_PRIORITY_EN
    logic unused_pointer;
    assign unused_pointer = ^pointer;

    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (request[i]) begin
                grant       = '0;
                grant[i]    = 1'b1;
                grant_index = INDEX_WIDTH'(i);
                grant_valid = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        for (int offset = 0; offset < NUM_REQUESTERS; offset++) begin
            idx = (int'(pointer) + offset) % NUM_REQUESTERS;
            if (!found && request[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                grant_index  = INDEX_WIDTH'(idx);
                grant_valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/commit_arbiter.sv
// Per-unit holding registers feeding one registered commit port through an arbiter.
// DRAGONFANG_COMMIT_FIXED_PRIORITY_EN selects fixed priority and removes rr_pointer.
module commit_arbiter
    import dragonfang_pkg::*;
#(
    parameter int NUM_FUNCTIONAL_UNITS = DEFAULT_NUM_FUNCTIONAL_UNITS,
    parameter int FU_ID_WIDTH          = $clog2(NUM_FUNCTIONAL_UNITS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  execution_output_packet_t        execution_output_packet [NUM_FUNCTIONAL_UNITS],
    input  logic [NUM_FUNCTIONAL_UNITS-1:0] execution_valid,
    output logic [NUM_FUNCTIONAL_UNITS-1:0] execution_ready,
    output commit_input_packet_t            commit_input_packet,
    output logic                            commit_valid,
    input  logic                            commit_ready,
    output logic [FU_ID_WIDTH-1:0]          commit_grant_id,
    output logic                            commit_id_error
);

    localparam int PKT_BITS = $bits(commit_input_packet_t);

    commit_input_packet_t            hold [NUM_FUNCTIONAL_UNITS];
    logic [NUM_FUNCTIONAL_UNITS-1:0] occupied;
    logic [NUM_FUNCTIONAL_UNITS-1:0] request;
    logic [NUM_FUNCTIONAL_UNITS-1:0] release_grant;
    logic [NUM_FUNCTIONAL_UNITS-1:0] transfer;
    logic [NUM_FUNCTIONAL_UNITS-1:0] id_mismatch;
    logic [FU_ID_WIDTH-1:0]          arb_pointer;
    logic [FU_ID_WIDTH-1:0]          grant_index;
    logic                            grant_valid;
    logic                            out_load;
    logic [PKT_BITS-1:0]             granted_bits;

    // Gating the requests with out_load keeps a stalled output from granting.
    assign out_load = !commit_valid || commit_ready;
    assign request  = out_load ? occupied : '0;

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_FUNCTIONAL_UNITS),
        .INDEX_WIDTH    (FU_ID_WIDTH)
    ) u_rr_arbiter (
        .request     (request),
        .pointer     (arb_pointer),
        .grant       (release_grant),
        .grant_index (grant_index),
        .grant_valid (grant_valid)
    );

    assign execution_ready = ~occupied | release_grant;
    assign transfer        = execution_valid & execution_ready;

    always_comb begin
        id_mismatch = '0;
        for (int i = 0; i < NUM_FUNCTIONAL_UNITS; i++) begin
            id_mismatch[i] = transfer[i] &&
                (execution_output_packet[i].functional_unit_id != FU_ID_FIELD_WIDTH'(i));
        end
    end

    always_comb begin
        granted_bits = '0;
        for (int i = 0; i < NUM_FUNCTIONAL_UNITS; i++) begin
            if (release_grant[i]) begin
                granted_bits = granted_bits | PKT_BITS'(hold[i]);
            end
        end
    end

    // A same-cycle refill wins over the release of the granted slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occupied <= '0;
            for (int i = 0; i < NUM_FUNCTIONAL_UNITS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            occupied <= transfer | (occupied & ~release_grant);
            for (int i = 0; i < NUM_FUNCTIONAL_UNITS; i++) begin
                if (transfer[i]) begin
                    hold[i] <= pack_execution_to_commit(execution_output_packet[i]);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_valid        <= 1'b0;
            commit_input_packet <= '0;
            commit_grant_id     <= '0;
        end else if (out_load) begin
            if (grant_valid) begin
                commit_valid        <= 1'b1;
                commit_input_packet <= commit_input_packet_t'(granted_bits);
                commit_grant_id     <= grant_index;
            end else begin
                commit_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_id_error <= 1'b0;
        end else if (|id_mismatch) begin
            commit_id_error <= 1'b1;
        end
    end

`ifdef DRAGONFANG_COMMIT_FIXED_PRIORITY_EN
    assign arb_pointer = '0;
`else
    logic [FU_ID_WIDTH-1:0] rr_pointer;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_pointer <= '0;
        end else if (grant_valid) begin
            rr_pointer <= (grant_index == FU_ID_WIDTH'(NUM_FUNCTIONAL_UNITS - 1))
                          ? '0 : grant_index + 1'b1;
        end
    end

    assign arb_pointer = rr_pointer;
`endif

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed and randomized checks of commit_arbiter against a transaction-level model.
module tb_commit_arbiter;
    import dragonfang_pkg::*;

    localparam int N = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    execution_output_packet_t exec_pkt [N];
    logic [N-1:0]             exec_valid;
    logic [N-1:0]             exec_ready;
    commit_input_packet_t     commit_pkt;
    logic                     commit_valid;
    logic                     commit_ready;
    logic [1:0]               commit_grant_id;
    logic                     commit_id_error;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: one pending slot per unit, the output register, and the search start.
    bit                   m_pend [N];
    commit_input_packet_t m_hold [N];
    commit_input_packet_t m_pkt;
    bit                   m_valid;
    int                   m_gid;
    int                   m_ptr;
    bit                   m_err;

    always #5 clock = ~clock;

    commit_arbiter dut (
        .clock                   (clock),
        .reset                   (reset),
        .execution_output_packet (exec_pkt),
        .execution_valid         (exec_valid),
        .execution_ready         (exec_ready),
        .commit_input_packet     (commit_pkt),
        .commit_valid            (commit_valid),
        .commit_ready            (commit_ready),
        .commit_grant_id         (commit_grant_id),
        .commit_id_error         (commit_id_error)
    );

    task automatic check_bits(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_hold[i] = '0;
        end
        m_pkt   = '0;
        m_valid = 1'b0;
        m_gid   = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
    endfunction

    function automatic int model_winner(input bit rdy);
        int idx;
        if (m_valid && !rdy) return -1;
        for (int k = 0; k < N; k++) begin
`ifdef DRAGONFANG_COMMIT_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (m_ptr + k) % N;
`endif
            if (m_pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_pkt(input int i, input int id, input int addr, input logic [31:0] vd);
        exec_pkt[i].functional_unit_id         = FU_ID_FIELD_WIDTH'(id);
        exec_pkt[i].vector_destination_address = VREG_ADDR_WIDTH'(addr);
        exec_pkt[i].vd                         = vd;
    endtask

    task automatic randomize_pkts(input bit allow_bad_id);
        for (int i = 0; i < N; i++) begin
            if (allow_bad_id && $urandom_range(0, 31) == 0)
                set_pkt(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), $urandom);
            else
                set_pkt(i, i, int'($urandom_range(0, 31)), $urandom);
        end
    endtask

    task automatic check_outputs();
        check_bits("commit_valid", 64'(commit_valid), 64'(m_valid));
        check_bits("commit_input_packet", 64'(commit_pkt), 64'(m_pkt));
        check_bits("commit_grant_id", 64'(commit_grant_id), 64'(m_gid));
        check_bits("commit_id_error", 64'(commit_id_error), 64'(m_err));
    endtask

    // One cycle: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic step(input logic [N-1:0] v, input bit rdy);
        int           w;
        logic [N-1:0] er;
        @(negedge clock);
        exec_valid   = v;
        commit_ready = rdy;
        #1;
        w = model_winner(rdy);
        for (int i = 0; i < N; i++) er[i] = !m_pend[i] || (w == i);
        check_bits("execution_ready", 64'(exec_ready), 64'(er));
        @(posedge clock);
        if (w >= 0) begin
            m_pkt     = m_hold[w];
            m_gid     = w;
            m_valid   = 1'b1;
            m_pend[w] = 1'b0;
            m_ptr     = (w + 1) % N;
        end else if (!m_valid || rdy) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (v[i] && er[i]) begin
                m_pend[i]                            = 1'b1;
                m_hold[i].vd                         = exec_pkt[i].vd;
                m_hold[i].vector_destination_address = exec_pkt[i].vector_destination_address;
                if (int'(exec_pkt[i].functional_unit_id) != i) m_err = 1'b1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        reset      = 1'b1;
        exec_valid = '0;
        #1;
        model_reset();
        check_bits("reset_commit_valid", 64'(commit_valid), 64'(0));
        check_bits("reset_execution_ready", 64'(exec_ready), 64'(4'b1111));
        @(negedge clock);
        #2;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        reset        = 1'b1;
        exec_valid   = '0;
        commit_ready = 1'b1;
        randomize_pkts(1'b0);
        model_reset();
        #1;
        check_outputs();
        check_bits("reset_ready_initial", 64'(exec_ready), 64'(4'b1111));
        @(negedge clock);
        #2;
        reset = 1'b0;

        // Single packet on unit 0: visible two edges later for one cycle.
        set_pkt(0, 0, 3, 32'h0000_00A5);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // All units streaming: back-to-back refills, one commit per cycle.
        for (int c = 0; c < 12; c++) begin
            randomize_pkts(1'b0);
            step(4'b1111, 1'b1);
        end
        for (int c = 0; c < 5; c++) step(4'b0000, 1'b1);

        // Fill everything, stall the output, then drain.
        randomize_pkts(1'b0);
        step(4'b1111, 1'b1);
        randomize_pkts(1'b0);
        step(4'b1111, 1'b0);
        for (int c = 0; c < 5; c++) step(4'b1111, 1'b0);
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b1);

        // Mis-tagged packet on unit 2.
        set_pkt(2, 1, 7, 32'hDEAD_0002);
        step(4'b0100, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1);

        // Asynchronous reset with three slots occupied and the output valid.
        randomize_pkts(1'b0);
        step(4'b0111, 1'b1);
        randomize_pkts(1'b0);
        step(4'b0111, 1'b0);
        async_reset();
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1);

        // Refill of unit 1 in the same cycle it is granted.
        set_pkt(1, 1, 1, 32'h1111_0001);
        step(4'b0010, 1'b1);
        set_pkt(1, 1, 2, 32'h2222_0002);
        step(4'b0010, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b1);

        // Randomized traffic with occasional stalls and rare ID errors.
        for (int c = 0; c < 400; c++) begin
            randomize_pkts(1'b1);
            step(N'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
            if (c == 200) async_reset();
        end
        for (int c = 0; c < 8; c++) step(4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
